// File: rtl/uart_mult_sched.sv
// Round-robin scheduler for a shared 16x16 multiply cell.
// Builds a 64-bit product over one or two cell passes and returns one word.
module uart_mult_sched (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        req0_valid,
  output logic        req0_ready,
  input  logic [31:0] req0_a,
  input  logic [31:0] req0_b,
  input  logic        req0_hi,
  input  logic        req1_valid,
  output logic        req1_ready,
  input  logic [31:0] req1_a,
  input  logic [31:0] req1_b,
  input  logic        req1_hi,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic        resp_id,
  output logic [31:0] resp_data,
  output logic [31:0] cell_src1,
  output logic [31:0] cell_src2,
  output logic        cell_en,
  input  logic [31:0] cell_p1,
  input  logic [31:0] cell_p2,
  input  logic [31:0] cell_p3
);

  typedef enum logic [2:0] {
    IDLE, ISSUE1, CAP1, ISSUE2, CAP2, DONE
  } state_t;

  state_t      state, nxt;
  logic        rr_ptr;
  logic        gnt;
  logic        hs;
  logic        id_q;
  logic        hi_q;
  logic [15:0] a_hi;
  logic [15:0] b_hi;
  logic [63:0] acc;
  logic [31:0] sel_a;
  logic [31:0] sel_b;
  logic        sel_hi;

  // Contention goes to rr_ptr; a lone requester always wins.
  always_comb begin
    if (req0_valid && req1_valid) gnt = rr_ptr;
    else                          gnt = req1_valid;
  end

  assign sel_a  = gnt ? req1_a  : req0_a;
  assign sel_b  = gnt ? req1_b  : req0_b;
  assign sel_hi = gnt ? req1_hi : req0_hi;
  assign hs     = req0_ready | req1_ready;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= nxt;
  end

  always_comb begin
    nxt        = state;
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    cell_en    = 1'b0;
    resp_valid = 1'b0;
    resp_id    = 1'b0;
    resp_data  = '0;
    unique case (state)
      IDLE: begin
        req0_ready = req0_valid & ~gnt;
        req1_ready = req1_valid & gnt;
        if (req0_valid | req1_valid) nxt = ISSUE1;
      end
      ISSUE1: begin
        cell_en = 1'b1;
        nxt     = CAP1;
      end
      CAP1: nxt = hi_q ? ISSUE2 : DONE;
      ISSUE2: begin
        cell_en = 1'b1;
        nxt     = CAP2;
      end
      CAP2: nxt = DONE;
      DONE: begin
        resp_valid = 1'b1;
        resp_id    = id_q;
        resp_data  = hi_q ? acc[63:32] : acc[31:0];
        if (resp_ready) nxt = IDLE;
      end
      default: nxt = IDLE;
    endcase
  end

  // Operands go to the cell a cycle early so they are stable in ISSUE.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rr_ptr    <= 1'b0;
      id_q      <= 1'b0;
      hi_q      <= 1'b0;
      a_hi      <= '0;
      b_hi      <= '0;
      acc       <= '0;
      cell_src1 <= '0;
      cell_src2 <= '0;
    end else begin
      if (hs) begin
        rr_ptr    <= ~gnt;
        id_q      <= gnt;
        hi_q      <= sel_hi;
        a_hi      <= sel_a[31:16];
        b_hi      <= sel_b[31:16];
        cell_src1 <= sel_a;
        cell_src2 <= sel_b;
      end
      if (state == CAP1) begin
        acc <= {32'h0, cell_p1}
             + {16'h0, cell_p2, 16'h0}
             + {16'h0, cell_p3, 16'h0};
        if (hi_q) begin
          cell_src1 <= {16'h0, a_hi};
          cell_src2 <= {16'h0, b_hi};
        end
      end
      if (state == CAP2) acc <= acc + {cell_p1, 32'h0};
    end
  end

endmodule

// File: tb/tb_uart_mult_sched.sv
// Bench for uart_mult_sched with a behavioural multiply cell.
// Expected words come from a queue filled at each request handshake.
module tb_uart_mult_sched;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        req0_valid = 1'b0, req1_valid = 1'b0;
  logic        req0_ready, req1_ready;
  logic [31:0] req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
  logic        req0_hi = 1'b0, req1_hi = 1'b0;
  logic        resp_valid, resp_id;
  logic        resp_ready = 1'b1;
  logic [31:0] resp_data, cell_src1, cell_src2;
  logic        cell_en;
  logic [31:0] cell_p1 = '0, cell_p2 = '0, cell_p3 = '0;

  typedef struct packed {
    logic        id;
    logic [31:0] data;
  } exp_t;

  exp_t sb[$];
  int checks = 0;
  int errors = 0;
  int en_cnt = 0;
  int rdy_bad = 0;

  uart_mult_sched dut (
    .clk(clk), .reset_n(reset_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready),
    .req0_a(req0_a), .req0_b(req0_b), .req0_hi(req0_hi),
    .req1_valid(req1_valid), .req1_ready(req1_ready),
    .req1_a(req1_a), .req1_b(req1_b), .req1_hi(req1_hi),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_id(resp_id), .resp_data(resp_data),
    .cell_src1(cell_src1), .cell_src2(cell_src2),
    .cell_en(cell_en),
    .cell_p1(cell_p1), .cell_p2(cell_p2), .cell_p3(cell_p3)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (cell_en) begin
      cell_p1 <= {16'h0, cell_src1[15:0]} * {16'h0, cell_src2[15:0]};
      cell_p2 <= {16'h0, cell_src1[15:0]} * {16'h0, cell_src2[31:16]};
      cell_p3 <= {16'h0, cell_src1[31:16]} * {16'h0, cell_src2[15:0]};
    end
  end

  function automatic exp_t mk(input logic id, input logic [31:0] a,
                              input logic [31:0] b, input logic hi);
    logic [63:0] p;
    exp_t e;
    p = {32'h0, a} * {32'h0, b};
    e.id = id;
    e.data = hi ? p[63:32] : p[31:0];
    return e;
  endfunction

  always @(negedge clk) begin
    if (cell_en) en_cnt++;
    if ((req0_ready || req1_ready) && (resp_valid || cell_en)) rdy_bad++;
    if (req0_ready && req1_ready) rdy_bad++;
    if (req0_valid && req0_ready) sb.push_back(mk(1'b0, req0_a, req0_b, req0_hi));
    if (req1_valid && req1_ready) sb.push_back(mk(1'b1, req1_a, req1_b, req1_hi));
  end

  task automatic run_op(input logic id, input logic [31:0] a,
                        input logic [31:0] b, input logic hi,
                        input int lat, input int pulses, input string nm);
    int k;
    int e0;
    exp_t ex;
    resp_ready = 1'b1;
    if (id) begin
      req1_a = a; req1_b = b; req1_hi = hi; req1_valid = 1'b1;
    end else begin
      req0_a = a; req0_b = b; req0_hi = hi; req0_valid = 1'b1;
    end
    k = 0;
    @(negedge clk);
    while (!(req0_ready || req1_ready) && k < 20) begin
      @(negedge clk);
      k++;
    end
    checks++;
    if ((id ? req1_ready : req0_ready) !== 1'b1) begin
      errors++;
      $display("FAIL %s_grant: ready0=%b ready1=%b, wanted requester %0d",
               nm, req0_ready, req1_ready, id);
    end
    e0 = en_cnt;
    @(posedge clk); #1;
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    k = 1;
    @(negedge clk);
    while (!resp_valid && k < 20) begin
      @(negedge clk);
      k++;
    end
    checks++;
    if (k !== lat) begin
      errors++;
      $display("FAIL %s_latency: got %0d cycles, expected %0d", nm, k, lat);
    end
    ex = '0;
    if (sb.size() > 0) ex = sb.pop_front();
    checks++;
    if (resp_id !== ex.id || resp_data !== ex.data) begin
      errors++;
      $display("FAIL %s_data: got id=%b data=%h, expected id=%b data=%h",
               nm, resp_id, resp_data, ex.id, ex.data);
    end
    checks++;
    if (en_cnt - e0 !== pulses) begin
      errors++;
      $display("FAIL %s_pulses: got %0d cell_en pulses, expected %0d",
               nm, en_cnt - e0, pulses);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset_n = 1'b1;
    @(negedge clk);
    checks++;
    if (resp_valid !== 1'b0 || resp_id !== 1'b0 || resp_data !== 32'h0 ||
        cell_en !== 1'b0 || cell_src1 !== 32'h0 || cell_src2 !== 32'h0 ||
        req0_ready !== 1'b0 || req1_ready !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: got v=%b id=%b d=%h en=%b s1=%h s2=%h r=%b%b, expected all zero",
               resp_valid, resp_id, resp_data, cell_en, cell_src1, cell_src2,
               req0_ready, req1_ready);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_mult();
    run_op(1'b0, 32'd3, 32'd5, 1'b0, 3, 1, "low_3x5");
    run_op(1'b1, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 5, 2, "ones_hi");
    run_op(1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 3, 1, "ones_lo");
    run_op(1'b1, 32'h00010000, 32'h00010000, 1'b1, 5, 2, "carry_hi");
    run_op(1'b0, 32'h00010000, 32'h00010000, 1'b0, 3, 1, "carry_lo");
    run_op(1'b1, 32'h0000FFFF, 32'h00010001, 1'b0, 3, 1, "ffff_lo");
    run_op(1'b0, 32'h89ABCDEF, 32'hFEDCBA98, 1'b1, 5, 2, "mixed_hi");
    run_op(1'b1, 32'h12345678, 32'h9ABCDEF0, 1'b0, 3, 1, "mixed_lo");
  endtask

  task automatic test_fairness();
    int n;
    int k;
    int bad0;
    exp_t ex;
    bad0 = rdy_bad;
    resp_ready = 1'b1;
    req0_a = 32'd7; req0_b = 32'd9; req0_hi = 1'b0;
    req1_a = 32'hDEADBEEF; req1_b = 32'hCAFEF00D; req1_hi = 1'b1;
    req0_valid = 1'b1;
    req1_valid = 1'b1;
    n = 0;
    k = 0;
    while (n < 6 && k < 200) begin
      @(negedge clk);
      k++;
      if (resp_valid) begin
        ex = '0;
        if (sb.size() > 0) ex = sb.pop_front();
        checks++;
        if (resp_id !== n[0] || resp_data !== ex.data) begin
          errors++;
          $display("FAIL fair_op%0d: got id=%b data=%h, expected id=%b data=%h",
                   n, resp_id, resp_data, n[0], ex.data);
        end
        n++;
      end
    end
    @(posedge clk); #1;
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    checks++;
    if (n !== 6) begin
      errors++;
      $display("FAIL fair_count: got %0d responses, expected 6", n);
    end
    checks++;
    if (rdy_bad !== bad0) begin
      errors++;
      $display("FAIL fair_ready_idle: got %0d ready violations, expected 0",
               rdy_bad - bad0);
    end
  endtask

  task automatic test_backpressure();
    int k;
    exp_t ex;
    resp_ready = 1'b0;
    req0_a = 32'h00012345; req0_b = 32'h00067890; req0_hi = 1'b1;
    req0_valid = 1'b1;
    k = 0;
    @(negedge clk);
    while (!req0_ready && k < 20) begin
      @(negedge clk);
      k++;
    end
    @(posedge clk); #1;
    req0_valid = 1'b0;
    req1_valid = 1'b1;
    k = 0;
    @(negedge clk);
    while (!resp_valid && k < 20) begin
      @(negedge clk);
      k++;
    end
    ex = '0;
    if (sb.size() > 0) ex = sb.pop_front();
    for (int i = 0; i < 5; i++) begin
      if (i > 0) @(negedge clk);
      checks++;
      if (resp_valid !== 1'b1 || resp_data !== ex.data || resp_id !== 1'b0 ||
          req0_ready !== 1'b0 || req1_ready !== 1'b0 || cell_en !== 1'b0) begin
        errors++;
        $display("FAIL stall_%0d: got v=%b d=%h id=%b r=%b%b en=%b, expected v=1 d=%h id=0 r=00 en=0",
                 i, resp_valid, resp_data, resp_id, req0_ready, req1_ready,
                 cell_en, ex.data);
      end
    end
    @(posedge clk); #1;
    req1_valid = 1'b0;
    resp_ready = 1'b1;
    @(negedge clk);
    checks++;
    if (resp_valid !== 1'b1 || resp_data !== ex.data) begin
      errors++;
      $display("FAIL release_hold: got v=%b d=%h, expected v=1 d=%h",
               resp_valid, resp_data, ex.data);
    end
    @(posedge clk); #1;
    req0_a = 32'd11; req0_b = 32'd13; req0_hi = 1'b0;
    req0_valid = 1'b1;
    @(negedge clk);
    checks++;
    if (resp_valid !== 1'b0 || req0_ready !== 1'b1) begin
      errors++;
      $display("FAIL release_idle: got v=%b ready0=%b, expected v=0 ready0=1",
               resp_valid, req0_ready);
    end
    @(posedge clk); #1;
    req0_valid = 1'b0;
    k = 1;
    @(negedge clk);
    while (!resp_valid && k < 20) begin
      @(negedge clk);
      k++;
    end
    ex = '0;
    if (sb.size() > 0) ex = sb.pop_front();
    checks++;
    if (k !== 3 || resp_data !== ex.data || resp_id !== 1'b0) begin
      errors++;
      $display("FAIL after_stall: got lat=%0d d=%h id=%b, expected lat=3 d=%h id=0",
               k, resp_data, resp_id, ex.data);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_midop();
    int k;
    int seen;
    exp_t ex;
    resp_ready = 1'b1;
    req0_a = 32'hFFFF0001; req0_b = 32'h0003FFFF; req0_hi = 1'b1;
    req0_valid = 1'b1;
    k = 0;
    @(negedge clk);
    while (!req0_ready && k < 20) begin
      @(negedge clk);
      k++;
    end
    @(posedge clk); #1;
    req0_valid = 1'b0;
    @(posedge clk); #1;
    reset_n = 1'b0;
    #1;
    checks++;
    if (resp_valid !== 1'b0 || resp_id !== 1'b0 || resp_data !== 32'h0 ||
        cell_en !== 1'b0 || cell_src1 !== 32'h0 || cell_src2 !== 32'h0 ||
        req0_ready !== 1'b0 || req1_ready !== 1'b0) begin
      errors++;
      $display("FAIL midop_reset: got v=%b id=%b d=%h en=%b s1=%h s2=%h r=%b%b, expected all zero",
               resp_valid, resp_id, resp_data, cell_en, cell_src1, cell_src2,
               req0_ready, req1_ready);
    end
    sb.delete();
    seen = 0;
    repeat (3) begin
      @(negedge clk);
      if (resp_valid || cell_en) seen++;
    end
    @(posedge clk); #1;
    reset_n = 1'b1;
    repeat (3) begin
      @(negedge clk);
      if (resp_valid || cell_en) seen++;
    end
    checks++;
    if (seen !== 0) begin
      errors++;
      $display("FAIL midop_discard: got %0d cycles with activity, expected 0", seen);
    end
    @(posedge clk); #1;
    req0_a = 32'd6; req0_b = 32'd7; req0_hi = 1'b0;
    req1_a = 32'd2; req1_b = 32'd3; req1_hi = 1'b0;
    req0_valid = 1'b1;
    req1_valid = 1'b1;
    @(negedge clk);
    checks++;
    if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin
      errors++;
      $display("FAIL midop_rr: got ready0=%b ready1=%b, expected ready0=1 ready1=0",
               req0_ready, req1_ready);
    end
    @(posedge clk); #1;
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    k = 1;
    @(negedge clk);
    while (!resp_valid && k < 20) begin
      @(negedge clk);
      k++;
    end
    ex = '0;
    if (sb.size() > 0) ex = sb.pop_front();
    checks++;
    if (k !== 3 || resp_id !== 1'b0 || resp_data !== 32'd42 ||
        ex.data !== 32'd42) begin
      errors++;
      $display("FAIL midop_next: got lat=%0d id=%b d=%h, expected lat=3 id=0 d=%h",
               k, resp_id, resp_data, 32'd42);
    end
    @(posedge clk); #1;
  endtask

  initial begin
    test_reset();
    test_mult();
    test_fairness();
    test_backpressure();
    test_reset_midop();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
